// File: rtl/bank_write_arbiter.sv
// bank_write_arbiter
//
// Shares the register bank's single write port between two requesters using
// round-robin arbitration, and provides a hardware clear sweep that writes
// zero to every register in ascending address order.
//
// Parameters:
//   AW  address width (bank depth is 2**AW registers)
//   DW  data width
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req0/addr0/dat0     requester 0 write request (held until ack0)
//   ack0                one-cycle pulse: requester 0's write is on the port
//   req1/addr1/dat1     requester 1 write request (held until ack1)
//   ack1                one-cycle pulse: requester 1's write is on the port
//   clr_start           pulse that starts the clear sweep
//   clr_busy            high while the clear sweep owns the write port
//   clr_done            one-cycle pulse after the last clear write
//   addrW/datW/RegWrite registered write port to the bank
module bank_write_arbiter #(
   parameter int AW = 3,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] dat0,
   output logic          ack0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] dat1,
   output logic          ack1,
   input  logic          clr_start,
   output logic          clr_busy,
   output logic          clr_done,
   output logic [AW-1:0] addrW,
   output logic [DW-1:0] datW,
   output logic          RegWrite
);

   typedef enum logic {
      ST_ARB = 1'b0,
      ST_CLR = 1'b1
   } state_t;

   // The sweep counter is one bit wider than the address so that reaching
   // 2**AW marks the end of the sweep.
   localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] CNT_LAST = {1'b1, {AW{1'b0}}};

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW-1:0] addr_w_q, addr_w_d;
   logic [DW-1:0] dat_w_q, dat_w_d;
   logic          reg_write_q, reg_write_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          clr_busy_q, clr_busy_d;
   logic          clr_done_q, clr_done_d;

   logic          elig0, elig1;
   logic          grant0, grant1;
   logic          arb_en;

   // A requester acked this cycle is still holding req high; masking it
   // keeps the same request from being written a second time.
   always_comb begin
      elig0  = req0 && !ack0_q;
      elig1  = req1 && !ack1_q;
      grant0 = elig0 && (!elig1 || (ptr_q == 1'b0));
      grant1 = elig1 && (!elig0 || (ptr_q == 1'b1));
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      addr_w_d    = addr_w_q;
      dat_w_d     = dat_w_q;
      reg_write_d = 1'b0;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      clr_busy_d  = clr_busy_q;
      clr_done_d  = 1'b0;
      arb_en      = 1'b0;

      case (state_q)
         ST_ARB: begin
            // A clear request beats any pending write; those requests stay
            // pending and are served once the sweep finishes.
            if (clr_start) begin
               state_d     = ST_CLR;
               addr_w_d    = '0;
               dat_w_d     = '0;
               reg_write_d = 1'b1;
               clr_busy_d  = 1'b1;
               cnt_d       = CNT_ONE;
            end else begin
               arb_en = 1'b1;
            end
         end
         ST_CLR: begin
            if (cnt_q < CNT_LAST) begin
               addr_w_d    = cnt_q[AW-1:0];
               dat_w_d     = '0;
               reg_write_d = 1'b1;
               cnt_d       = cnt_q + CNT_ONE;
            end else begin
               // The exit edge also arbitrates, so a stalled request can be
               // granted in the same cycle that clr_done pulses.
               state_d    = ST_ARB;
               clr_busy_d = 1'b0;
               clr_done_d = 1'b1;
               cnt_d      = '0;
               arb_en     = 1'b1;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase

      if (arb_en) begin
         if (grant0) begin
            addr_w_d    = addr0;
            dat_w_d     = dat0;
            reg_write_d = 1'b1;
            ack0_d      = 1'b1;
            ptr_d       = 1'b1;
         end else if (grant1) begin
            addr_w_d    = addr1;
            dat_w_d     = dat1;
            reg_write_d = 1'b1;
            ack1_d      = 1'b1;
            ptr_d       = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARB;
         ptr_q       <= 1'b0;
         cnt_q       <= '0;
         addr_w_q    <= '0;
         dat_w_q     <= '0;
         reg_write_q <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         addr_w_q    <= addr_w_d;
         dat_w_q     <= dat_w_d;
         reg_write_q <= reg_write_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         clr_busy_q  <= clr_busy_d;
         clr_done_q  <= clr_done_d;
      end
   end

   assign addrW    = addr_w_q;
   assign datW     = dat_w_q;
   assign RegWrite = reg_write_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_bank_write_arbiter.sv
// tb_bank_write_arbiter
//
// Directed testbench for bank_write_arbiter. Stimulus pushes each expected
// bank write onto a queue; a monitor pops and compares whenever RegWrite is
// seen. A small bank model records the writes so register contents can be
// checked after each scenario.
module tb_bank_write_arbiter;

   localparam int AW    = 3;
   localparam int DW    = 4;
   localparam int DEPTH = 1 << AW;

   localparam int KIND_REQ0 = 0;
   localparam int KIND_REQ1 = 1;
   localparam int KIND_CLR  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, clr_start;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] dat0, dat1;
   logic          ack0, ack1, clr_busy, clr_done, RegWrite;
   logic [AW-1:0] addrW;
   logic [DW-1:0] datW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
      int            kind;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          exp_e;
   logic [DW-1:0] bank [0:DEPTH-1];

   int checks    = 0;
   int errors    = 0;
   int done_seen = 0;
   int exp_done  = 0;

   bank_write_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .addr0    (addr0),
      .dat0     (dat0),
      .ack0     (ack0),
      .req1     (req1),
      .addr1    (addr1),
      .dat1     (dat1),
      .ack1     (ack1),
      .clr_start(clr_start),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .addrW    (addrW),
      .datW     (datW),
      .RegWrite (RegWrite)
   );

   always #5 clk = ~clk;

   // Bank model: the write port is sampled on the rising edge.
   always @(posedge clk) begin
      if (RegWrite) bank[addrW] <= datW;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic cs);
      req0      = r0;
      addr0     = a0;
      dat0      = d0;
      req1      = r1;
      addr1     = a1;
      dat1      = d1;
      clr_start = cs;
   endtask

   task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int kind);
      exp_t e;
      e.addr = a;
      e.dat  = d;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   task automatic waitAck(input int which, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if ((which == 0) ? ack0 : ack1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: ack%0d got 0, expected 1 within 40 cycles", name, which);
      end
   endtask

   task automatic waitDone(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (clr_done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: clr_done got 0, expected 1 within 40 cycles", name);
      end
   endtask

   // One requester write: raise req, hold until ack, drop it.
   task automatic doWrite(input int which, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      @(negedge clk);
      pushExp(a, d, which);
      if (which == 0) applyStimulus(1'b1, a, d, 1'b0, '0, '0, 1'b0);
      else            applyStimulus(1'b0, '0, '0, 1'b1, a, d, 1'b0);
      waitAck(which, "preload ack");
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   // Scoreboard monitor: every bank write must match the oldest expectation.
   always @(negedge clk) begin
      if (clr_done) done_seen++;
      if (RegWrite) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected write: got addr %0d dat %0d, expected no write",
                     addrW, datW);
         end else begin
            exp_e = exp_q.pop_front();
            checkOutput("scoreboard addrW", 32'(addrW), 32'(exp_e.addr));
            checkOutput("scoreboard datW", 32'(datW), 32'(exp_e.dat));
            checkOutput("scoreboard ack0", 32'(ack0), 32'(exp_e.kind == KIND_REQ0));
            checkOutput("scoreboard ack1", 32'(ack1), 32'(exp_e.kind == KIND_REQ1));
            checkOutput("scoreboard clr_busy", 32'(clr_busy), 32'(exp_e.kind == KIND_CLR));
         end
      end else if (ack0 || ack1) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack without write: got ack0=%0d ack1=%0d, expected 0",
                  ack0, ack1);
      end
   end

   initial begin
      int d0;

      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset RegWrite", 32'(RegWrite), 0);
      checkOutput("reset addrW", 32'(addrW), 0);
      checkOutput("reset datW", 32'(datW), 0);
      checkOutput("reset ack0", 32'(ack0), 0);
      checkOutput("reset ack1", 32'(ack1), 0);
      checkOutput("reset clr_busy", 32'(clr_busy), 0);
      checkOutput("reset clr_done", 32'(clr_done), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] single requester");
      @(negedge clk);
      pushExp(3'd5, 4'd9, KIND_REQ0);
      applyStimulus(1'b1, 3'd5, 4'd9, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("single latency ack0", 32'(ack0), 1);
      checkOutput("single latency RegWrite", 32'(RegWrite), 1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("single bank[5]", 32'(bank[5]), 9);

      // Fresh reset so the pointer starts at requester 0.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] contention");
      @(negedge clk);
      pushExp(3'd1, 4'd3, KIND_REQ0);
      pushExp(3'd2, 4'd4, KIND_REQ1);
      pushExp(3'd1, 4'd3, KIND_REQ0);
      pushExp(3'd2, 4'd4, KIND_REQ1);
      applyStimulus(1'b1, 3'd1, 4'd3, 1'b1, 3'd2, 4'd4, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);

      $display("[TB] held request");
      @(negedge clk);
      for (int i = 0; i < 3; i++) pushExp(3'd6, 4'd10, KIND_REQ1);
      applyStimulus(1'b0, '0, '0, 1'b1, 3'd6, 4'd10, 1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);

      $display("[TB] full clear");
      for (int i = 0; i < DEPTH; i++) doWrite(0, AW'(i), DW'(i));
      @(posedge clk);
      #1;
      checkOutput("preload bank[6]", 32'(bank[6]), 6);
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) pushExp(AW'(i), '0, KIND_CLR);
      exp_done++;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      waitDone("full clear done");
      for (int i = 0; i < DEPTH; i++) checkOutput("cleared bank", 32'(bank[i]), 0);
      repeat (2) @(posedge clk);

      $display("[TB] clear versus request");
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) pushExp(AW'(i), '0, KIND_CLR);
      pushExp(3'd3, 4'd7, KIND_REQ0);
      exp_done++;
      d0 = done_seen;
      applyStimulus(1'b1, 3'd3, 4'd7, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b1, 3'd3, 4'd7, 1'b0, '0, '0, 1'b0);
      waitAck(0, "clear vs request ack0");
      checkOutput("ack0 not before clr_done", 32'(clr_done || (done_seen > d0)), 1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("clear vs request bank[3]", 32'(bank[3]), 7);

      $display("[TB] reset mid-clear");
      for (int i = 4; i < DEPTH; i++) doWrite(1, AW'(i), DW'(i + 7));
      @(negedge clk);
      for (int i = 0; i < 4; i++) pushExp(AW'(i), '0, KIND_CLR);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid-clear reset RegWrite", 32'(RegWrite), 0);
      checkOutput("mid-clear reset clr_busy", 32'(clr_busy), 0);
      checkOutput("mid-clear reset clr_done", 32'(clr_done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("mid-clear bank[3]", 32'(bank[3]), 0);
      for (int i = 4; i < DEPTH; i++) checkOutput("mid-clear kept bank", 32'(bank[i]), i + 7);

      @(negedge clk);
      checkOutput("pending expectations", 32'(exp_q.size()), 0);
      checkOutput("clr_done pulses", 32'(done_seen), 32'(exp_done));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
